vx_gbar_collector: RTL and testbench

// - Global-barrier responder: terminates the per-core gbar request channel driven by each core's warp scheduler.
// - Collects arrivals per barrier id across cores; when the last expected core arrives, broadcasts a

---
 rtl/vx_gbar_collector.sv | 161 ++++++++++++++++
 tb/tb_vx_gbar_collector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_gbar_collector.sv
// vx_gbar_collector: cluster-level global-barrier responder.
// Collects per-core barrier arrivals through a round-robin arbiter (one accept per
// cycle). When the last expected core of a barrier id arrives, a single-cycle
// release carrying that id is broadcast to all cores.
// Handshake: a request transfers when req_valid[g] & req_ready[g]. req_ready is
// one-hot or zero and depends combinationally on req_valid. The response has no
// ready, so cores must sample rsp_id in the cycle rsp_valid is high.
// Barrier ids must be below NUM_BARRIERS.
// Optional feature macro: GBAR_PERF_EN adds release and wait-cycle counters.
// dbg_dup_arrival / dbg_size_mismatch pulse in the accepting cycle of a duplicate
// arrival or of a completion with a disagreeing barrier size.

module vx_gbar_collector #(
   parameter int NUM_CORES     = 4,
   parameter int NUM_BARRIERS  = 8,
   parameter int PERF_CTR_BITS = 44,
   localparam int NB_W  = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   localparam int NC_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int CNT_W = $clog2(NUM_CORES + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CORES-1:0]         req_valid,
   output logic [NUM_CORES-1:0]         req_ready,
   input  logic [NUM_CORES*NB_W-1:0]    req_id,
   input  logic [NUM_CORES*NC_W-1:0]    req_size_m1,
   output logic                         rsp_valid,
   output logic [NB_W-1:0]              rsp_id,
   output logic                         busy,
   output logic                         dbg_dup_arrival,
   output logic                         dbg_size_mismatch
`ifdef GBAR_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0]     perf_releases,
   output logic [PERF_CTR_BITS-1:0]     perf_wait_cycles
`endif
);

   // Per-barrier arrival bookkeeping, packed so whole-table clears are one assignment.
   logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] arrive_mask_q, arrive_mask_d;
   logic [NUM_BARRIERS-1:0][CNT_W-1:0]     arrive_cnt_q, arrive_cnt_d;
   logic [NC_W-1:0]                        rr_ptr_q, rr_ptr_d;
   logic                                   rsp_valid_q, rsp_valid_d;
   logic [NB_W-1:0]                        rsp_id_q, rsp_id_d;

   logic                                   fire;
   logic [NC_W-1:0]                        gnt_idx;
   logic [NB_W-1:0]                        sel_id;
   logic [NC_W-1:0]                        sel_size;
   logic [CNT_W-1:0]                       new_cnt;
   logic [CNT_W-1:0]                       need_cnt;
   logic                                   any_pending;
   int                                     arb_idx;

   // Round-robin search starting at rr_ptr; the first requesting core wins.
   always_comb begin
      fire     = 1'b0;
      gnt_idx  = '0;
      sel_id   = '0;
      sel_size = '0;
      arb_idx  = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         arb_idx = int'(rr_ptr_q) + i;
         if (arb_idx >= NUM_CORES) begin
            arb_idx = arb_idx - NUM_CORES;
         end
         if (!fire && req_valid[arb_idx]) begin
            fire     = 1'b1;
            gnt_idx  = NC_W'(arb_idx);
            sel_id   = req_id[arb_idx*NB_W +: NB_W];
            sel_size = req_size_m1[arb_idx*NC_W +: NC_W];
         end
      end
      req_ready = fire ? (NUM_CORES'(1) << gnt_idx) : '0;
      if (!fire) begin
         rr_ptr_d = rr_ptr_q;
      end else if (gnt_idx == NC_W'(NUM_CORES - 1)) begin
         rr_ptr_d = '0;
      end else begin
         rr_ptr_d = gnt_idx + 1'b1;
      end
   end

   // Apply the accepted arrival: duplicate, completion (release) or plain arrival.
   always_comb begin
      arrive_mask_d     = arrive_mask_q;
      arrive_cnt_d      = arrive_cnt_q;
      rsp_valid_d       = 1'b0;
      rsp_id_d          = rsp_id_q;
      dbg_dup_arrival   = 1'b0;
      dbg_size_mismatch = 1'b0;
      new_cnt           = arrive_cnt_q[sel_id] + CNT_W'(1);
      need_cnt          = CNT_W'(sel_size) + CNT_W'(1);
      if (fire) begin
         if (arrive_mask_q[sel_id][gnt_idx]) begin
            // Same core arrived twice in one generation: accepted, otherwise ignored.
            dbg_dup_arrival = 1'b1;
         end else if (new_cnt >= need_cnt) begin
            // Overshoot means cores disagree on the size; release anyway so nobody hangs.
            arrive_mask_d[sel_id] = '0;
            arrive_cnt_d[sel_id]  = '0;
            rsp_valid_d           = 1'b1;
            rsp_id_d              = sel_id;
            dbg_size_mismatch     = (new_cnt > need_cnt);
         end else begin
            arrive_mask_d[sel_id][gnt_idx] = 1'b1;
            arrive_cnt_d[sel_id]           = new_cnt;
         end
      end
   end

   // Activity indication: pending arrivals anywhere or a release on the wire.
   always_comb begin
      any_pending = |arrive_cnt_q;
      busy        = any_pending | rsp_valid_q;
      rsp_valid   = rsp_valid_q;
      rsp_id      = rsp_id_q;
   end

   // State registers; reset discards every pending arrival.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         arrive_mask_q <= '0;
         arrive_cnt_q  <= '0;
         rr_ptr_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
      end else begin
         arrive_mask_q <= arrive_mask_d;
         arrive_cnt_q  <= arrive_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
      end
   end

`ifdef GBAR_PERF_EN
   logic [PERF_CTR_BITS-1:0] perf_releases_q, perf_releases_d;
   logic [PERF_CTR_BITS-1:0] perf_wait_q, perf_wait_d;

   // Free-running event counters; wrap naturally at full scale.
   always_comb begin
      perf_releases_d  = perf_releases_q + (rsp_valid_q ? PERF_CTR_BITS'(1) : '0);
      perf_wait_d      = perf_wait_q + (any_pending ? PERF_CTR_BITS'(1) : '0);
      perf_releases    = perf_releases_q;
      perf_wait_cycles = perf_wait_q;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_releases_q <= '0;
         perf_wait_q     <= '0;
      end else begin
         perf_releases_q <= perf_releases_d;
         perf_wait_q     <= perf_wait_d;
      end
   end
`endif

endmodule

// File: tb/tb_vx_gbar_collector.sv
// Testbench for vx_gbar_collector: directed barrier scenarios followed by random
// traffic, every cycle compared against a set/count model of barrier arrivals.

module tb_vx_gbar_collector;

   localparam int NC   = 4;
   localparam int NBAR = 8;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [11:0] req_id = '0;
   logic [7:0]  req_size_m1 = '0;
   logic        rsp_valid;
   logic [2:0]  rsp_id;
   logic        busy;
   logic        dbg_dup_arrival;
   logic        dbg_size_mismatch;

   always #5 clk = ~clk;

   vx_gbar_collector dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_id            (req_id),
      .req_size_m1       (req_size_m1),
      .rsp_valid         (rsp_valid),
      .rsp_id            (rsp_id),
      .busy              (busy),
      .dbg_dup_arrival   (dbg_dup_arrival),
      .dbg_size_mismatch (dbg_size_mismatch)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // Which cores have arrived at each barrier in the current generation.
   bit   m_arr[NBAR][NC];
   int   m_cnt[NBAR];
   int   m_rr;
   bit   m_rsp_v;
   int   m_rsp_id;

   // Stimulus for the next cycle.
   logic [3:0] d_v;
   int         d_id[NC];
   int         d_sz[NC];
   int         sz_tab[NBAR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NBAR; b++) begin
         m_cnt[b] = 0;
         for (int c = 0; c < NC; c++) m_arr[b][c] = 1'b0;
      end
      m_rr     = 0;
      m_rsp_v  = 1'b0;
      m_rsp_id = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      d_v = 4'b0000;
   endtask

   task automatic set_req(input int core, input int id, input int sz);
      d_v[core]  = 1'b1;
      d_id[core] = id;
      d_sz[core] = sz;
   endtask

   // One clock cycle: drive at the falling edge, compare, then advance the model
   // to what the following rising edge should produce.
   task automatic cyc();
      int  g;
      int  b;
      int  n;
      bit  exp_dup;
      bit  exp_mis;
      bit  comp;
      bit  any;
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
         req_valid[i]           = d_v[i];
         req_id[i*3 +: 3]       = 3'(d_id[i]);
         req_size_m1[i*2 +: 2]  = 2'(d_sz[i]);
      end
      #1;
      g = -1;
      for (int k = 0; k < NC; k++) begin
         int c;
         c = (m_rr + k) % NC;
         if (g < 0 && d_v[c]) g = c;
      end
      exp_dup = 1'b0;
      exp_mis = 1'b0;
      comp    = 1'b0;
      b       = 0;
      n       = 0;
      if (g >= 0) begin
         b = d_id[g];
         if (m_arr[b][g]) begin
            exp_dup = 1'b1;
         end else begin
            n = m_cnt[b] + 1;
            if (n >= d_sz[g] + 1) begin
               comp    = 1'b1;
               exp_mis = (n > d_sz[g] + 1);
            end
         end
      end
      any = m_rsp_v;
      for (int j = 0; j < NBAR; j++) if (m_cnt[j] != 0) any = 1'b1;

      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
      if (m_rsp_v) chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      chk("busy", 32'(busy), 32'(any));
      chk("dup_flag", 32'(dbg_dup_arrival), 32'(exp_dup));
      chk("size_flag", 32'(dbg_size_mismatch), 32'(exp_mis));

      if (g >= 0) begin
         m_rr = (g + 1) % NC;
         if (!exp_dup) begin
            if (comp) begin
               for (int c = 0; c < NC; c++) m_arr[b][c] = 1'b0;
               m_cnt[b] = 0;
               m_rsp_id = b;
            end else begin
               m_arr[b][g] = 1'b1;
               m_cnt[b]    = n;
            end
         end
      end
      m_rsp_v = comp;
   endtask

   // Direct look at the release one cycle after the last driven cycle.
   task automatic expect_rsp(input string tag, input logic v, input int id);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      if (v) chk({tag, "_id"}, 32'(rsp_id), 32'(id));
   endtask

   task automatic do_reset();
      @(negedge clk);
      d_v       = 4'b0000;
      req_valid = 4'b0000;
      reset     = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      for (int i = 0; i < NC; i++) begin
         d_id[i] = 0;
         d_sz[i] = 0;
      end
      d_v = 4'b0000;
      model_reset();
      do_reset();
      cyc();

      // All four cores join id 2; each stays valid until granted.
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < NC; c++) set_req(c, 2, 3);
         d_v = 4'b1111 << k;
         cyc();
      end
      idle();
      expect_rsp("all4", 1'b1, 2);
      cyc();
      cyc();

      // Two interleaved 2-core barriers, ids 1 and 5.
      idle(); set_req(1, 1, 1); cyc();
      idle(); set_req(3, 5, 1); cyc();
      idle(); set_req(0, 1, 1); cyc();
      expect_rsp("id1", 1'b1, 1);
      idle(); set_req(2, 5, 1); cyc();
      expect_rsp("id5", 1'b1, 5);
      idle(); cyc(); cyc(); cyc();

      // Fairness: grant core1 first so the search starts at core2.
      idle(); set_req(1, 4, 0); cyc();
      idle(); set_req(0, 0, 0); set_req(1, 6, 0); set_req(3, 7, 0); cyc();
      expect_rsp("rr_core3", 1'b1, 7);
      d_v[3] = 1'b0; cyc();
      expect_rsp("rr_core0", 1'b1, 0);
      d_v[0] = 1'b0; cyc();
      expect_rsp("rr_core1", 1'b1, 6);
      idle(); cyc(); cyc();

      // Duplicate arrival from core0 on id 0, then core1 completes it.
      idle(); set_req(0, 0, 1); cyc();
      cyc();
      idle(); cyc();
      idle(); set_req(1, 0, 1); cyc();
      expect_rsp("dup_done", 1'b1, 0);
      idle(); cyc(); cyc();

      // Single-core barrier releases one cycle after its arrival.
      idle(); set_req(2, 7, 0); cyc();
      expect_rsp("single", 1'b1, 7);
      idle(); cyc(); cyc();

      // Size disagreement: third arrival on a 1-core-sized request overshoots.
      idle(); set_req(0, 6, 3); cyc();
      idle(); set_req(1, 6, 3); cyc();
      idle(); set_req(2, 6, 0); cyc();
      expect_rsp("mismatch", 1'b1, 6);
      idle(); cyc(); cyc();

      // Reset with two arrivals pending on id 3, then a fresh 2-core barrier.
      idle(); set_req(0, 3, 2); cyc();
      idle(); set_req(1, 3, 2); cyc();
      do_reset();
      idle(); cyc();
      idle(); set_req(2, 3, 1); cyc();
      idle(); set_req(3, 3, 1); cyc();
      expect_rsp("post_reset", 1'b1, 3);
      idle(); cyc(); cyc();

      // Random traffic with mostly consistent per-barrier sizes.
      for (int b = 0; b < NBAR; b++) sz_tab[b] = $urandom_range(0, 3);
      for (int t = 0; t < 600; t++) begin
         d_v = 4'($urandom_range(0, 15));
         for (int c = 0; c < NC; c++) begin
            d_id[c] = $urandom_range(0, NBAR - 1);
            d_sz[c] = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : sz_tab[d_id[c]];
         end
         cyc();
      end
      idle();
      for (int t = 0; t < 4; t++) cyc();

      // ---------------- final report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
